// File: rtl/linear_interp_48_if.sv
// Sample-stream bundle between the Ks/Kd scaling stage, the interpolator and the MPX adder.
// The master drives the frame/output strobes and the input sample; the slave returns the ramp.
interface linear_interp_48_if;
  logic               clken_in;
  logic               clken_out;
  logic signed [17:0] din;
  logic               din_valid;
  logic signed [17:0] dout;
  logic               dout_valid;
  logic               underrun;
  logic               overrun;

  modport master (
    output clken_in, clken_out, din, din_valid,
    input  dout, dout_valid, underrun, overrun
  );

  modport slave (
    input  clken_in, clken_out, din, din_valid,
    output dout, dout_valid, underrun, overrun
  );
endinterface

// File: rtl/linear_interp_48.sv
// Per-channel linear interpolator: one 48 kHz sample in, 2^LOG2L ramped samples out per frame.
// A sample captured during frame n ramps from x_{n-1} toward x_n across frame n+1.
module linear_interp_48 #(
  parameter int LOG2L = 2
) (
  input  logic                clock,
  input  logic                reset,
  linear_interp_48_if.slave   bus
);

  localparam int L     = 1 << LOG2L;
  localparam int ACC_W = 19 + LOG2L;
  localparam int K_W   = (LOG2L > 0) ? LOG2L : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(L - 1);

  typedef enum logic {EMPTY, LOADED} pend_state_t;

  pend_state_t               pend_state_q, pend_state_d;
  logic                      din_valid_d_q, din_valid_d_d;
  logic signed [17:0]        pending_q, pending_d;
  logic signed [17:0]        x_curr_q, x_curr_d;
  logic signed [18:0]        delta_q, delta_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic        [K_W-1:0]     k_q, k_d;
  logic                      underrun_q, underrun_d;
  logic                      overrun_q, overrun_d;
  logic signed [17:0]        dout_q, dout_d;
  logic                      dout_valid_q, dout_valid_d;

  logic                      new_sample;
  logic                      pend_v;
  logic signed [17:0]        x_new;
  logic signed [18:0]        delta_new;
  logic signed [ACC_W-1:0]   acc_base;
  logic signed [ACC_W-1:0]   acc_eff;
  logic signed [18:0]        delta_eff;
  logic        [K_W-1:0]     k_eff;

  // The *_eff values are what an output strobe sees: the fresh frame state when
  // clken_in coincides with clken_out, otherwise the running ramp.
  always_comb begin
    new_sample = bus.din_valid & ~din_valid_d_q;
    pend_v     = (pend_state_q == LOADED);
    x_new      = pend_v ? pending_q : x_curr_q;
    delta_new  = 19'(x_new) - 19'(x_curr_q);
    acc_base   = ACC_W'(x_curr_q) <<< LOG2L;

    pend_state_d  = pend_state_q;
    din_valid_d_d = bus.din_valid;
    pending_d     = pending_q;
    x_curr_d      = x_curr_q;
    delta_d       = delta_q;
    acc_d         = acc_q;
    k_d           = k_q;
    underrun_d    = underrun_q;
    overrun_d     = overrun_q;
    dout_d        = dout_q;
    dout_valid_d  = 1'b0;
    acc_eff       = acc_q;
    delta_eff     = delta_q;
    k_eff         = k_q;

    if (bus.clken_in) begin
      x_curr_d     = x_new;
      delta_d      = delta_new;
      acc_d        = acc_base;
      k_d          = '0;
      pend_state_d = EMPTY;
      if (!pend_v) begin
        underrun_d = 1'b1;
      end
      acc_eff   = acc_base;
      delta_eff = delta_new;
      k_eff     = '0;
    end

    // A sample arriving with clken_in lands after the frame update, for the next frame.
    if (new_sample) begin
      pending_d    = bus.din;
      pend_state_d = LOADED;
      if (pend_v && !bus.clken_in) begin
        overrun_d = 1'b1;
      end
    end

    if (bus.clken_out) begin
      dout_d       = 18'(acc_eff >>> LOG2L);
      dout_valid_d = 1'b1;
      if (k_eff < K_LAST) begin
        acc_d = acc_eff + ACC_W'(delta_eff);
        k_d   = k_eff + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_state_q  <= EMPTY;
      din_valid_d_q <= 1'b0;
      pending_q     <= '0;
      x_curr_q      <= '0;
      delta_q       <= '0;
      acc_q         <= '0;
      k_q           <= '0;
      underrun_q    <= 1'b0;
      overrun_q     <= 1'b0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
    end else begin
      pend_state_q  <= pend_state_d;
      din_valid_d_q <= din_valid_d_d;
      pending_q     <= pending_d;
      x_curr_q      <= x_curr_d;
      delta_q       <= delta_d;
      acc_q         <= acc_d;
      k_q           <= k_d;
      underrun_q    <= underrun_d;
      overrun_q     <= overrun_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.underrun   = underrun_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_linear_interp_48.sv
// Directed scoreboard bench for linear_interp_48 (L = 4): frames of 16 cycles,
// expected ramp values queued at stimulus time and popped by a dout_valid monitor.
module tb_linear_interp_48;

  logic clock;
  logic reset;
  int   vecCount;
  int   missCount;
  int   sbQ[$];

  linear_interp_48_if bus();

  linear_interp_48 #(.LOG2L(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic expectOut(input int value);
    sbQ.push_back(value);
  endtask

  // One frame: clken_in at cycle 0, clken_out wherever outMask has a bit set,
  // up to two din_valid rising edges, and an optional two-cycle reset pulse.
  task automatic applyStimulus(input int edgeA, input int valA,
                               input int edgeB, input int valB,
                               input logic [15:0] outMask, input int resetAt);
    for (int c = 0; c < 16; c++) begin
      @(posedge clock);
      #1;
      bus.clken_in  = (c == 0);
      bus.clken_out = outMask[c];
      bus.din_valid = (c == edgeA) || (c == edgeB);
      if (c == edgeA) bus.din = 18'(valA);
      if (c == edgeB) bus.din = 18'(valB);
      reset = (resetAt >= 0) && ((c == resetAt) || (c == resetAt + 1));
    end
    @(posedge clock);
    #1;
    bus.clken_in  = 1'b0;
    bus.clken_out = 1'b0;
    bus.din_valid = 1'b0;
    reset         = 1'b0;
  endtask

  task automatic preload(input int value);
    @(posedge clock);
    #1;
    bus.din       = 18'(value);
    bus.din_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.din_valid = 1'b0;
  endtask

  task automatic checkFlags(input string tag, input int expUnder, input int expOver);
    @(posedge clock);
    #2;
    checkOutput({tag, "_underrun"}, int'(bus.underrun), expUnder);
    checkOutput({tag, "_overrun"}, int'(bus.overrun), expOver);
  endtask

  always @(negedge clock) begin
    if (bus.dout_valid === 1'b1) begin
      if (sbQ.size() == 0) begin
        vecCount++;
        missCount++;
        $display("[TB] FAIL unexpected_dout: got %0d, expected no output", int'(bus.dout));
      end else begin
        checkOutput("dout", int'(bus.dout), sbQ.pop_front());
      end
    end
  end

  localparam logic [15:0] STD_MASK = 16'h1111;

  initial begin
    vecCount      = 0;
    missCount     = 0;
    reset         = 1'b1;
    bus.clken_in  = 1'b0;
    bus.clken_out = 1'b0;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("reset_dout", int'(bus.dout), 0);
    checkOutput("reset_dout_valid", int'(bus.dout_valid), 0);
    checkOutput("reset_underrun", int'(bus.underrun), 0);
    checkOutput("reset_overrun", int'(bus.overrun), 0);

    preload(0);
    for (int i = 0; i < 4; i++) expectOut(0);
    applyStimulus(5, 400, -1, 0, STD_MASK, -1);

    expectOut(0); expectOut(100); expectOut(200); expectOut(300);
    applyStimulus(5, -3, -1, 0, STD_MASK, -1);

    expectOut(400); expectOut(299); expectOut(198); expectOut(97);
    applyStimulus(5, 131071, -1, 0, STD_MASK, -1);

    expectOut(-3); expectOut(32765); expectOut(65534); expectOut(98302);
    applyStimulus(5, -131072, -1, 0, STD_MASK, -1);

    expectOut(131071); expectOut(65535); expectOut(-1); expectOut(-65537);
    applyStimulus(-1, 0, -1, 0, STD_MASK, -1);
    checkFlags("full_scale", 0, 0);

    for (int i = 0; i < 4; i++) expectOut(-131072);
    applyStimulus(-1, 0, -1, 0, STD_MASK, -1);
    checkFlags("underrun", 1, 0);

    for (int i = 0; i < 4; i++) expectOut(-131072);
    applyStimulus(3, 10, 7, 20, STD_MASK, -1);
    checkFlags("overrun", 1, 1);

    expectOut(-131072); expectOut(-98299); expectOut(-65526); expectOut(-32753);
    expectOut(-32753);
    applyStimulus(0, 50, -1, 0, 16'h5111, -1);

    expectOut(20); expectOut(27); expectOut(35); expectOut(42);
    applyStimulus(-1, 0, -1, 0, STD_MASK, -1);

    expectOut(50); expectOut(50);
    applyStimulus(2, 1000, -1, 0, 16'h0111, 7);
    #1;
    checkOutput("midreset_dout", int'(bus.dout), 0);
    checkOutput("midreset_dout_valid", int'(bus.dout_valid), 0);
    checkOutput("midreset_underrun", int'(bus.underrun), 0);
    checkOutput("midreset_overrun", int'(bus.overrun), 0);

    for (int i = 0; i < 4; i++) expectOut(0);
    applyStimulus(-1, 0, -1, 0, STD_MASK, -1);

    repeat (4) @(posedge clock);
    #2;
    checkOutput("scoreboard_leftover", sbQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
